// File: rtl/bit_serial_adder_pkg.sv
// Purpose: shared types and constants for the bit-serial adder and the tile top level.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_serial_adder_pkg;

  // Default operand/result width; legal range is 2..16.
  localparam int WIDTH_DEFAULT = 8;

  // COLLECT: shifting in operand bit pairs. DONE: holding a finished result.
  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/bit_serial_adder_half_adder.sv
// Purpose: half adder cell (a, b -> s, c), purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: a, b operand bits; s = a ^ b; c = a & b.
module bit_serial_adder_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/bit_serial_adder.sv
// Purpose: LSB-first bit-serial adder; accumulates WIDTH bit pairs into {cout, sum_out}.
// Latency: out_valid rises 1 cycle after the WIDTH-th accepted bit pair.
// Backpressure: result held while out_ready=0; in_ready=0 until the result is taken.
// Ports:
//   clk, rst_n (sync, active-low), flush (sync abort of partial word/result)
//   a_bit, b_bit, in_valid / in_ready    : serial operand feed
//   sum_out, cout, out_valid / out_ready : completed result
//   bit_cnt                              : bit pairs accepted in current word
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_cnt
);

  state_e state;
  state_e state_nxt;

  logic carry;
  logic ha0_s;
  logic ha0_c;
  logic sum_bit;
  logic ha1_c;
  logic carry_nxt;

  logic accept;
  logic last_beat;
  logic out_fire;

  // Full-adder bit slice: two half adders, carries ORed (they never both fire).
  bit_serial_adder_half_adder u_ha0 (
    .a (a_bit),
    .b (b_bit),
    .s (ha0_s),
    .c (ha0_c)
  );

  bit_serial_adder_half_adder u_ha1 (
    .a (ha0_s),
    .b (carry),
    .s (sum_bit),
    .c (ha1_c)
  );

  assign carry_nxt = ha0_c | ha1_c;

  // Decoded from state directly rather than from in_ready/out_valid so the
  // next-state logic has no path back through its own outputs.
  assign accept    = in_valid && (state == COLLECT);
  assign out_fire  = out_ready && (state == DONE);
  assign last_beat = (bit_cnt == CNT_W'(WIDTH - 1));

  // State register; flush forces COLLECT in the next-state logic below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = COLLECT;
        end
      end
      default: begin
        state_nxt = COLLECT;
      end
    endcase
    // Abort wins over both a completing beat and an output handshake.
    if (flush) begin
      state_nxt = COLLECT;
    end
  end

  // Datapath: carry flop, bit counter, result shift register and cout.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      if (accept) begin
        carry   <= carry_nxt;
        // New bit enters at the MSB, so after WIDTH shifts the first bit sits at bit 0.
        sum_out <= {sum_bit, sum_out[WIDTH-1:1]};
        if (last_beat) begin
          bit_cnt <= '0;
          cout    <= carry_nxt;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      // The finished word's carry must not seed the next word.
      if (out_fire) begin
        carry <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          a_bit;
  logic          b_bit;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  sum_out;
  logic          cout;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] bit_cnt;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bit_cnt   (bit_cnt)
  );

  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result is consumed on out_valid && out_ready unless flush/reset drops it.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {23'd0, cout, sum_out}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {23'd0, cout, sum_out}, {23'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit pair and hold it until accepted (bounded).
  task automatic send_beat(input logic a, input logic b, input bit rand_mode);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    a_bit    = a;
    b_bit    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit rand_mode, input bit push);
    if (push) exp_q.push_back({1'b0, a} + {1'b0, b});
    for (int i = 0; i < W; i++) begin
      send_beat(a[i], b[i], rand_mode);
      if (i == W - 1) begin
        check("latency_out_valid", {31'd0, out_valid}, 1);
        check("bit_cnt_wrap", {{(32-CW){1'b0}}, bit_cnt}, 0);
      end else if (rand_mode) begin
        repeat ($urandom_range(0, 2)) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int guard;

    rst_n = 1'b0; flush = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready",  {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_bit_cnt",   {{(32-CW){1'b0}}, bit_cnt}, 0);
    check("rst_sum",       {24'd0, sum_out}, 0);
    check("rst_cout",      {31'd0, cout}, 0);
    rst_n = 1'b1;
    tick();

    // Basic word: 0x5A + 0x3C = 0x96
    send_word(8'h5A, 8'h3C, 0, 1);
    tick();
    check("in_ready_after_hs",  {31'd0, in_ready}, 1);
    check("out_valid_after_hs", {31'd0, out_valid}, 0);

    // Overflow then carry-isolation between words
    send_word(8'hFF, 8'h01, 0, 1);
    send_word(8'h80, 8'h80, 0, 1);

    // Gaps after beats 2 and 5: 0x0F + 0xF0 = 0xFF
    exp_q.push_back({1'b0, 8'h0F} + {1'b0, 8'hF0});
    ra = 8'h0F; rb = 8'hF0;
    for (int i = 0; i < W; i++) begin
      send_beat(ra[i], rb[i], 0);
      if (i == 1 || i == 4) begin
        repeat (3) begin
          check("bit_cnt_frozen", {{(32-CW){1'b0}}, bit_cnt}, i + 1);
          tick();
        end
      end
    end
    check("gap_latency", {31'd0, out_valid}, 1);

    // Backpressure: 0x3C + 0x11 = 0x04D held for 5 cycles
    wait_idle();
    out_ready = 1'b0;
    send_word(8'h3C, 8'h11, 0, 1);
    repeat (5) begin
      a_bit = 1'($urandom); b_bit = 1'($urandom); in_valid = 1'b1;
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready",  {31'd0, in_ready}, 0);
      check("bp_hold",      {23'd0, cout, sum_out}, 32'h04D);
      check("bp_bit_cnt",   {{(32-CW){1'b0}}, bit_cnt}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", {31'd0, out_valid}, 0);

    // flush after 4 beats of 0xAA + 0x55, then 0x01 + 0x01 = 0x002
    ra = 8'hAA; rb = 8'h55;
    for (int i = 0; i < 4; i++) send_beat(ra[i], rb[i], 0);
    check("partial_cnt", {{(32-CW){1'b0}}, bit_cnt}, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_cnt", {{(32-CW){1'b0}}, bit_cnt}, 0);
    check("flush_sum", {24'd0, sum_out}, 0);
    send_word(8'h01, 8'h01, 0, 1);

    // Same abort via reset
    wait_idle();
    for (int i = 0; i < 4; i++) send_beat(ra[i], rb[i], 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_cnt",      {{(32-CW){1'b0}}, bit_cnt}, 0);
    check("rstmid_in_ready", {31'd0, in_ready}, 1);
    check("rstmid_sum",      {24'd0, sum_out}, 0);
    send_word(8'h01, 8'h01, 0, 1);

    // flush together with the 8th beat: result never appears
    wait_idle();
    ra = 8'hFF; rb = 8'hFF;
    for (int i = 0; i < W - 1; i++) send_beat(ra[i], rb[i], 0);
    a_bit = 1'b1; b_bit = 1'b1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush8_out_valid", {31'd0, out_valid}, 0);
    check("flush8_in_ready",  {31'd0, in_ready}, 1);
    check("flush8_cnt",       {{(32-CW){1'b0}}, bit_cnt}, 0);

    // flush together with the output handshake: result dropped
    out_ready = 1'b0;
    send_word(8'hC3, 8'h7E, 0, 0);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushhs_out_valid", {31'd0, out_valid}, 0);
    check("flushhs_in_ready",  {31'd0, in_ready}, 1);
    check("flushhs_cnt",       {{(32-CW){1'b0}}, bit_cnt}, 0);
    check("flushhs_cout",      {31'd0, cout}, 0);
    send_word(8'h01, 8'h01, 0, 1);

    // Randomized words with random gaps and random backpressure
    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send_word(ra, rb, 1, 1);
    end

    // Drain remaining results
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Downstream accumulating stage for the half-adder cell.
- Takes operand bit pairs (a, b) LSB-first over WIDTH cycles and chains the carry through a registered carry flop.
- Assembles the WIDTH-bit sum plus carry-out, then presents it on a valid/ready output handshake.
- Sits between the dedicated input pins (serial operand feed) and the dedicated output pins of the tile top level.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 2..16).
- CNT_W, $clog2(WIDTH), width of the bit counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- flush  input  1  synchronous abort: clears the partial word, carry and counter.
- a_bit  input  1  operand A bit, LSB-first.
- b_bit  input  1  operand B bit, LSB-first.
- in_valid  input  1  a_bit/b_bit valid this cycle.
- in_ready  output  1  stage accepts a bit pair this cycle.
- sum_out  output  WIDTH  completed sum word.
- cout  output  1  carry-out of the MSB addition.
- out_valid  output  1  sum_out/cout valid.
- out_ready  input  1  consumer accepts the result.
- bit_cnt  output  CNT_W  number of bit pairs accepted in the current word.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; all state updates on rising clk.
- Reset values: state=COLLECT, carry=0, bit_cnt=0, sum_out=0, cout=0, out_valid=0, in_ready=1.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready.
- On each accept in COLLECT:
  - s = a_bit ^ b_bit ^ carry, built from two half_adder instances plus an OR on the carries.
  - carry <= carry-out of that addition.
  - sum shift register <= {s, sum_reg[WIDTH-1:1]}, so the first bit lands in bit 0 after WIDTH shifts.
  - bit_cnt <= bit_cnt+1.
- Word completion: accept with bit_cnt==WIDTH-1.
  - Next cycle: state=DONE, out_valid=1, cout=final carry, bit_cnt wraps to 0.
  - Latency: out_valid rises exactly 1 cycle after the WIDTH-th accepted beat.
- Gaps: in_valid low in COLLECT holds carry, bit_cnt and the shift register unchanged. Gaps of any length are legal.
- DONE:
  - sum_out and cout are held stable while out_ready=0 (backpressure). Bit pairs presented meanwhile are not accepted.
  - On out_valid && out_ready, next cycle: state=COLLECT, carry=0, out_valid=0, in_ready=1.
  - sum_out keeps the last value until overwritten by shifting.
- Bubble: no accept occurs in the cycle the output handshake completes, giving one bubble cycle between words.
- flush=1 (any state): next cycle state=COLLECT, carry=0, bit_cnt=0, shift register=0, cout=0, out_valid=0.
  - flush has priority over a simultaneous input accept and over a simultaneous output handshake. A result dropped by flush is lost.
- rst_n=0 mid-word or in DONE: same effect as flush, and all outputs take reset values. rst_n has priority over flush.
- Arithmetic:
  - Modulo 2^WIDTH; cout carries the overflow.
  - {cout,sum_out} = A + B, with no carry-in.
- sum_out is a registered output, never driven combinationally from a_bit/b_bit.

Decomposition:
- Shared package: state enum (COLLECT, DONE) and the WIDTH default constant, reused by the tile top level.
- Natural sub-module: half_adder (a, b -> s, c), purely combinational, instantiated twice to form the full-adder bit slice.
- Carry flop, counter, shift register and FSM stay in bit_serial_adder.

Test Plan:
- Reset then A=0x5A, B=0x3C, 8 consecutive beats, out_ready=1 -> out_valid 1 cycle after beat 8; sum_out=0x96, cout=0; in_ready back to 1 on the following cycle.
- A=0xFF, B=0x01 -> sum_out=0x00, cout=1. Then A=0x80, B=0x80 -> sum_out=0x00, cout=1; carry does not leak across words (second result unaffected by the first carry).
- A=0x0F, B=0xF0 with in_valid low for 3 cycles after beats 2 and 5 -> sum_out=0xFF, cout=0; bit_cnt frozen during the gaps.
- Complete a word with out_ready=0 for 5 cycles -> out_valid held, sum_out stable, in_ready=0, a_bit/b_bit ignored; out_ready=1 releases it.
- flush after 4 beats of A=0xAA, B=0x55, then a full A=0x01, B=0x01 word -> sum_out=0x02, cout=0, proving the partial word and carry were cleared. Repeat the abort using rst_n=0 instead of flush, with the same result.
- flush asserted in the same cycle as the 8th beat and, separately, in the same cycle as out_ready in DONE -> no out_valid / result dropped, state COLLECT, bit_cnt=0.
